// File: rtl/udc_pkg.sv
// Shared types and limits for the up/down counter.
package udc_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } udc_mode_e;

    localparam int UDC_PRESCALE_MAX = 65535;

endpackage

// File: rtl/udc_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles.
// A restart discards any partial period and starts counting from zero.
module udc_prescaler
    import udc_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] phase_q;

    assign tick = enable && (phase_q == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q <= '0;
        end else if (restart) begin
            phase_q <= '0;
        end else if (enable) begin
            if (phase_q == LAST) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with programmable range, wrap/saturate mode,
// load/clear and terminal-count pulses. Define UDC_PRESCALER_EN to slow steps.
module updown_counter_mod
    import udc_pkg::*;
#(
    parameter int        WIDTH    = 8,
    parameter int        MIN_VAL  = 0,
    parameter int        MAX_VAL  = (1 << WIDTH) - 1,
    parameter udc_mode_e MODE     = MODE_WRAP,
    parameter int        PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             tc_up,
    output logic             tc_down,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH:0]   MIN_X  = (WIDTH + 1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MAX_P1 = MAX_X + (WIDTH + 1)'(1);
    localparam logic [WIDTH:0]   MIN_M1 = MIN_X - (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);

    if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
        $error("updown_counter_mod: WIDTH must be 1..30");
    end
    if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > (1 << WIDTH) - 1) begin : g_bad_range
        $error("updown_counter_mod: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
    end
    if (PRESCALE < 1 || PRESCALE > UDC_PRESCALE_MAX) begin : g_bad_prescale
        $error("updown_counter_mod: PRESCALE must be 1..65535");
    end

    logic [WIDTH-1:0] count_q;
    logic             tc_up_q;
    logic             tc_down_q;
    logic             tick;
    logic             restart;
    logic [WIDTH:0]   up_next;
    logic [WIDTH:0]   down_next;
    logic             hit_top;
    logic             hit_bottom;
    logic [WIDTH-1:0] load_clamped;

    assign restart = clear || load;

`ifdef UDC_PRESCALER_EN
    udc_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .restart(restart),
        .tick   (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Boundaries are found from the WIDTH+1 bit neighbours, so a full-range
    // counter sees MAX+1 as 2**WIDTH rather than a silent wrap to zero.
    always_comb begin
        up_next      = {1'b0, count_q} + (WIDTH + 1)'(1);
        down_next    = {1'b0, count_q} - (WIDTH + 1)'(1);
        hit_top      = (up_next == MAX_P1);
        hit_bottom   = (down_next == MIN_M1);
        load_clamped = load_val;
        if (int'(load_val) > MAX_VAL) begin
            load_clamped = MAX_W;
        end else if (int'(load_val) < MIN_VAL) begin
            load_clamped = MIN_W;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q   <= MIN_W;
            tc_up_q   <= 1'b0;
            tc_down_q <= 1'b0;
        end else if (clear) begin
            count_q   <= MIN_W;
            tc_up_q   <= 1'b0;
            tc_down_q <= 1'b0;
        end else if (load) begin
            count_q   <= load_clamped;
            tc_up_q   <= 1'b0;
            tc_down_q <= 1'b0;
        end else begin
            tc_up_q   <= 1'b0;
            tc_down_q <= 1'b0;
            if (enable && tick) begin
                if (up_down) begin
                    if (hit_top) begin
                        tc_up_q <= 1'b1;
                        if (MODE == MODE_WRAP) begin
                            count_q <= MIN_W;
                        end
                    end else begin
                        count_q <= up_next[WIDTH-1:0];
                    end
                end else begin
                    if (hit_bottom) begin
                        tc_down_q <= 1'b1;
                        if (MODE == MODE_WRAP) begin
                            count_q <= MAX_W;
                        end
                    end else begin
                        count_q <= down_next[WIDTH-1:0];
                    end
                end
            end
        end
    end

    assign count_out = count_q;
    assign tc_up     = tc_up_q;
    assign tc_down   = tc_down_q;
    assign at_max    = (count_q == MAX_W);
    assign at_min    = (count_q == MIN_W);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: wrap, saturate and offset-range
// instances share one stimulus stream; prescaled timing when UDC_PRESCALER_EN.
module tb_updown_counter_mod;
    import udc_pkg::*;

`ifdef UDC_PRESCALER_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic       clear;
    logic       load;
    logic [7:0] load_val;

    logic [7:0] w_count, s_count, m_count;
    logic       w_tcu, w_tcd, w_max, w_min;
    logic       s_tcu, s_tcd, s_max, s_min;
    logic       m_tcu, m_tcd, m_max, m_min;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(9), .MODE(MODE_WRAP), .PRESCALE(4)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_val(load_val), .count_out(w_count), .tc_up(w_tcu),
        .tc_down(w_tcd), .at_max(w_max), .at_min(w_min)
    );

    updown_counter_mod #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(9), .MODE(MODE_SAT), .PRESCALE(4)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_val(load_val), .count_out(s_count), .tc_up(s_tcu),
        .tc_down(s_tcd), .at_max(s_max), .at_min(s_min)
    );

    updown_counter_mod #(.WIDTH(8), .MIN_VAL(3), .MAX_VAL(255), .MODE(MODE_WRAP), .PRESCALE(4)) dut_m (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_val(load_val), .count_out(m_count), .tc_up(m_tcu),
        .tc_down(m_tcd), .at_max(m_max), .at_min(m_min)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then settle just past the active edge.
    task automatic applyStimulus(input logic en, input logic ud, input logic clr,
                                 input logic ld, input logic [7:0] lv);
        enable   = en;
        up_down  = ud;
        clear    = clr;
        load     = ld;
        load_val = lv;
        @(posedge clk);
        #1;
    endtask

    // Enabled cycles that do not complete a prescale period: nothing moves.
    task automatic advance(input logic ud, input logic [31:0] ew, input logic [31:0] es,
                           input logic [31:0] em);
        for (int i = 1; i < PS; i++) begin
            applyStimulus(1'b1, ud, 1'b0, 1'b0, 8'd0);
            checkOutput("hold_w", 32'(w_count), ew);
            checkOutput("hold_s", 32'(s_count), es);
            checkOutput("hold_m", 32'(m_count), em);
            checkOutput("hold_tc", 32'({w_tcu, w_tcd, s_tcu, s_tcd, m_tcu, m_tcd}), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("rst_w", 32'(w_count), 0);
        checkOutput("rst_m", 32'(m_count), 3);
        checkOutput("rst_flags_w", 32'({w_tcu, w_tcd, w_max, w_min}), 32'b0001);
        checkOutput("rst_min_m", 32'(m_min), 1);
        reset = 1'b1;

        for (int k = 1; k <= 10; k++) begin
            advance(1'b1, 32'((k - 1) % 10), 32'((k - 1 > 9) ? 9 : k - 1), 32'(2 + k));
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
            checkOutput("up_w", 32'(w_count), 32'(k % 10));
            checkOutput("up_tcu_w", 32'(w_tcu), 32'(k == 10));
            checkOutput("up_max_w", 32'(w_max), 32'(k == 9));
            checkOutput("up_m", 32'(m_count), 32'(3 + k));
        end
        checkOutput("sat_top_s", 32'(s_count), 9);
        checkOutput("sat_tcu_s", 32'(s_tcu), 1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("dis_w", 32'(w_count), 0);
        checkOutput("dis_m", 32'(m_count), 13);
        checkOutput("dis_tc", 32'({w_tcu, s_tcu, m_tcu}), 0);

        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        reset = 1'b1;
        checkOutput("rst2_s", 32'(s_count), 0);
        advance(1'b0, 0, 0, 3);
        checkOutput("dn_pre_min_w", 32'(w_min), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        checkOutput("dn1_w", 32'(w_count), 9);
        checkOutput("dn1_tcd_w", 32'(w_tcd), 1);
        checkOutput("dn1_min_w", 32'(w_min), 0);
        checkOutput("dn1_s", 32'(s_count), 0);
        checkOutput("dn1_tcd_s", 32'(s_tcd), 1);
        checkOutput("dn1_m", 32'(m_count), 255);
        checkOutput("dn1_tcd_m", 32'(m_tcd), 1);
        advance(1'b0, 9, 0, 255);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        checkOutput("dn2_w", 32'(w_count), 8);
        checkOutput("dn2_tcd_w", 32'(w_tcd), 0);
        checkOutput("dn2_tcd_s", 32'(s_tcd), 1);
        checkOutput("dn2_m", 32'(m_count), 254);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd8);
        checkOutput("ld8_s", 32'(s_count), 8);
        checkOutput("ld8_m", 32'(m_count), 8);
        for (int j = 1; j <= 3; j++) begin
            advance(1'b1, 32'((7 + j) % 10), 32'((7 + j > 9) ? 9 : 7 + j), 32'(7 + j));
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
            checkOutput("sat_s", 32'(s_count), 9);
            checkOutput("sat_tcu_s", 32'(s_tcu), 32'(j >= 2));
            checkOutput("sat_max_s", 32'(s_max), 1);
            checkOutput("sat_tcu_w", 32'(w_tcu), 32'(j == 2));
        end
        checkOutput("sat_w", 32'(w_count), 1);
        checkOutput("sat_m", 32'(m_count), 11);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd200);
        checkOutput("ld200_w", 32'(w_count), 9);
        checkOutput("ld200_m", 32'(m_count), 200);
        checkOutput("ld200_tc", 32'({w_tcu, s_tcu, m_tcu}), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
        checkOutput("ld1_w", 32'(w_count), 1);
        checkOutput("ld1_m", 32'(m_count), 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd255);
        checkOutput("ld255_m", 32'(m_count), 255);
        checkOutput("ld255_max_m", 32'(m_max), 1);
        advance(1'b1, 9, 9, 255);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("full_wrap_m", 32'(m_count), 3);
        checkOutput("full_tcu_m", 32'(m_tcu), 1);
        checkOutput("full_min_m", 32'(m_min), 1);
        checkOutput("wrap_w", 32'(w_count), 0);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'd5);
        checkOutput("clrld_w", 32'(w_count), 0);
        checkOutput("clrld_m", 32'(m_count), 3);
        advance(1'b0, 0, 0, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        checkOutput("mdn_m", 32'(m_count), 255);
        checkOutput("mdn_tcd_m", 32'(m_tcd), 1);
        checkOutput("mdn_w", 32'(w_count), 9);

`ifdef UDC_PRESCALER_EN
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("gap_ph2_w", 32'(w_count), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("gap_off_w", 32'(w_count), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("gap_ph3_w", 32'(w_count), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("gap_step_w", 32'(w_count), 1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'd5);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("mid_ph2_w", 32'(w_count), 5);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        reset = 1'b1;
        checkOutput("mid_rst_w", 32'(w_count), 0);
        checkOutput("mid_rst_tc", 32'({w_tcu, w_tcd}), 0);
        advance(1'b1, 0, 0, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("mid_step_w", 32'(w_count), 1);
`else
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("en_off_w", 32'(w_count), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("en_on_w", 32'(w_count), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        checkOutput("en_off2_w", 32'(w_count), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
